// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor table: PC-mux select encodings
// and the saturating-counter helpers used by the counter table.
// Counter helpers operate on a 4-bit container (largest supported counter
// width); callers cast the result down to their own counter width.
package bp_pkg;

  localparam int unsigned PCSEL_W   = 2;
  localparam int unsigned CNT_MAX_W = 4;

  localparam logic [PCSEL_W-1:0] PCSEL_SEQ     = 2'b00;
  localparam logic [PCSEL_W-1:0] PCSEL_ID_TGT  = 2'b01;
  localparam logic [PCSEL_W-1:0] PCSEL_EX_FALL = 2'b10;
  localparam logic [PCSEL_W-1:0] PCSEL_EX_TGT  = 2'b11;

  // Weakly not-taken: 2^(cnt_w-1)-1
  function automatic logic [CNT_MAX_W-1:0] cnt_reset_val(input int unsigned cnt_w);
    return CNT_MAX_W'((1 << (cnt_w - 1)) - 1);
  endfunction

  // Saturating increment/decrement, clamps at 0 and 2^cnt_w-1
  function automatic logic [CNT_MAX_W-1:0] sat_update(input logic [CNT_MAX_W-1:0] cnt,
                                                      input logic                 taken,
                                                      input int unsigned          cnt_w);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = CNT_MAX_W'((1 << cnt_w) - 1);
    if (taken) begin
      return (cnt == max_v) ? cnt : cnt + CNT_MAX_W'(1);
    end
    return (cnt == '0) ? cnt : cnt - CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// ENTRIES x CNT_W saturating counter array.
// Ports: clk_i/rst_i (async active-high reset to weakly not-taken),
//   rd_idx/rd_cnt    combinational read port,
//   wr_en/wr_idx/wr_taken  synchronous saturating update of one entry.
// A read and write to the same index in one cycle returns the pre-update value.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_reset_val(CNT_W));

  logic [CNT_W-1:0] mem [ENTRIES];

  // Training port; write enable gates any unknown index when idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem <= '{default: CNT_RST};
    end else if (wr_en) begin
      mem[wr_idx] <= CNT_W'(sat_update(CNT_MAX_W'(mem[wr_idx]), wr_taken, CNT_W));
    end
  end

  assign rd_cnt = mem[rd_idx];

endmodule

// File: rtl/branch_predictor_table.sv
// PC-indexed saturating-counter branch predictor with flush / PC-mux control.
// Predicts in ID, trains from resolved EX outcomes, resolves EX mispredicts
// ahead of ID predicted-taken redirects.
// Ports: clk_i, rst_i (async active-high); ID_Branch_i, ID_pc_i (ID lookup);
//   EX_Branch_i, EX_realTaken_i, EX_predTaken_i, EX_predIdx_i (EX resolve/train);
//   ID_predTaken_o, ID_predIdx_o, Flush_IF_ID_o, Flush_ID_EX_o, pc_select_o
//   (all combinational).
// Build option: BP_GSHARE_EN -- XOR a non-speculative global history into the
//   lookup index; undefined gives a pure bimodal table.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  parameter  int unsigned CNT_W   = 2,
  parameter  int unsigned PC_W    = 32,
  parameter  int unsigned HIST_W  = 6,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ID_Branch_i,
  input  logic [PC_W-1:0]    ID_pc_i,
  input  logic               EX_Branch_i,
  input  logic               EX_realTaken_i,
  input  logic               EX_predTaken_i,
  input  logic [IDX_W-1:0]   EX_predIdx_i,
  output logic               ID_predTaken_o,
  output logic [IDX_W-1:0]   ID_predIdx_o,
  output logic               Flush_IF_ID_o,
  output logic               Flush_ID_EX_o,
  output logic [PCSEL_W-1:0] pc_select_o
);

  logic [IDX_W-1:0] base_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic             unused_pc_bits;

  // Word-aligned PC bits select the entry
  assign base_idx       = ID_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{ID_pc_i[PC_W-1:IDX_W+2], ID_pc_i[1:0]};

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr;

  // History advances only on resolved branches, so it is never speculative
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr <= '0;
    end else if (EX_Branch_i) begin
      ghr <= HIST_W'({ghr, EX_realTaken_i});
    end
  end

  assign rd_idx = base_idx ^ IDX_W'(ghr);
`else
  localparam int unsigned unused_hist_w = HIST_W;

  assign rd_idx = base_idx;
`endif

  // Training uses the index carried down the pipe, never a recomputed one
  bp_counter_table #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (rd_idx),
    .rd_cnt   (rd_cnt),
    .wr_en    (EX_Branch_i),
    .wr_idx   (EX_predIdx_i),
    .wr_taken (EX_realTaken_i)
  );

  assign ID_predIdx_o   = rd_idx;
  assign ID_predTaken_o = rd_cnt[CNT_W-1];

  // Redirect priority: EX mispredict squashes any ID branch in the same cycle
  always_comb begin
    Flush_IF_ID_o = 1'b0;
    Flush_ID_EX_o = 1'b0;
    pc_select_o   = PCSEL_SEQ;
    if (EX_Branch_i && (EX_realTaken_i != EX_predTaken_i)) begin
      Flush_IF_ID_o = 1'b1;
      Flush_ID_EX_o = 1'b1;
      pc_select_o   = EX_realTaken_i ? PCSEL_EX_TGT : PCSEL_EX_FALL;
    end else if (ID_Branch_i && ID_predTaken_o) begin
      Flush_IF_ID_o = 1'b1;
      pc_select_o   = PCSEL_ID_TGT;
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed self-checking bench for branch_predictor_table (default bimodal
// build, ENTRIES=64, CNT_W=2). Expectations come from a small counter model
// and are queued at drive time, then popped and checked before the next edge.
module tb_branch_predictor_table;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ID_Branch_i;
  logic [31:0] ID_pc_i;
  logic        EX_Branch_i;
  logic        EX_realTaken_i;
  logic        EX_predTaken_i;
  logic [5:0]  EX_predIdx_i;
  logic        ID_predTaken_o;
  logic [5:0]  ID_predIdx_o;
  logic        Flush_IF_ID_o;
  logic        Flush_ID_EX_o;
  logic [1:0]  pc_select_o;

  branch_predictor_table dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ID_Branch_i    (ID_Branch_i),
    .ID_pc_i        (ID_pc_i),
    .EX_Branch_i    (EX_Branch_i),
    .EX_realTaken_i (EX_realTaken_i),
    .EX_predTaken_i (EX_predTaken_i),
    .EX_predIdx_i   (EX_predIdx_i),
    .ID_predTaken_o (ID_predTaken_o),
    .ID_predIdx_o   (ID_predIdx_o),
    .Flush_IF_ID_o  (Flush_IF_ID_o),
    .Flush_ID_EX_o  (Flush_ID_EX_o),
    .pc_select_o    (pc_select_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       pred;
    logic [5:0] idx;
    logic       fif;
    logic       fie;
    logic [1:0] sel;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    cnt_m[64];
  int    n_checks = 0;
  int    n_fails  = 0;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) cnt_m[i] = 1;
  endtask

  task automatic chk(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  // One pipeline cycle: drive, queue expectation, check mid-cycle, clock, train model
  task automatic apply(input string tag, input logic idb, input logic [31:0] pc,
                       input logic exb, input logic rt, input logic pt,
                       input logic [5:0] pidx);
    exp_t e;
    exp_t g;
    string t;
    int idx;
    ID_Branch_i    = idb;
    ID_pc_i        = pc;
    EX_Branch_i    = exb;
    EX_realTaken_i = rt;
    EX_predTaken_i = pt;
    EX_predIdx_i   = pidx;
    idx    = int'(pc[7:2]);
    e.idx  = pc[7:2];
    e.pred = (cnt_m[idx] >= 2);
    e.fif  = 1'b0;
    e.fie  = 1'b0;
    e.sel  = 2'b00;
    if (exb && (rt != pt)) begin
      e.fif = 1'b1;
      e.fie = 1'b1;
      e.sel = {1'b1, rt};
    end else if (idb && e.pred) begin
      e.fif = 1'b1;
      e.sel = 2'b01;
    end
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #4;
    g = sb_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "pred",   8'(ID_predTaken_o), 8'(g.pred));
    chk(t, "idx",    8'(ID_predIdx_o),   8'(g.idx));
    chk(t, "fl_ifid", 8'(Flush_IF_ID_o), 8'(g.fif));
    chk(t, "fl_idex", 8'(Flush_ID_EX_o), 8'(g.fie));
    chk(t, "pcsel",  8'(pc_select_o),    8'(g.sel));
    @(posedge clk_i);
    #1;
    if (exb && !rst_i) begin
      if (rt) cnt_m[int'(pidx)] = (cnt_m[int'(pidx)] == 3) ? 3 : cnt_m[int'(pidx)] + 1;
      else    cnt_m[int'(pidx)] = (cnt_m[int'(pidx)] == 0) ? 0 : cnt_m[int'(pidx)] - 1;
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    ID_Branch_i    = 1'b0;
    ID_pc_i        = '0;
    EX_Branch_i    = 1'b0;
    EX_realTaken_i = 1'b0;
    EX_predTaken_i = 1'b0;
    EX_predIdx_i   = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    // Reset state visible while still in reset, then after release
    apply("rst_hold", 1'b1, 32'h0000_0123, 1'b0, 1'b0, 1'b0, 6'd0);
    rst_i = 1'b0;
    apply("t1_reset", 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 6'd0);

    // T2: train idx 16 (PC 0x40) taken twice
    apply("t2_misp",  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd16);
    apply("t2_corr",  1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 6'd16);
    apply("t2_pred",  1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 6'd0);
    apply("t2_nbr",   1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 6'd0);

    // T3: saturate idx 5 upward, then one not-taken
    for (int i = 0; i < 5; i++) apply("t3_up", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 6'd5);
    apply("t3_sat",   1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 6'd0);
    apply("t3_dn",    1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd5);
    apply("t3_keep",  1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 6'd0);

    // T4: EX mispredict overrides ID taken-prediction in the same cycle
    apply("t4_prio",  1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b0, 6'd7);
    apply("t4_fall",  1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 6'd8);

    // T5: same-index read/write returns pre-update value
    apply("t5_same",  1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 6'd3);
    apply("t5_next",  1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 6'd0);

    // Lower saturation on idx 9, then climb back once
    for (int i = 0; i < 3; i++) apply("lo_dn", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd9);
    apply("lo_up",    1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd9);
    apply("lo_chk",   1'b1, 32'h0000_0024, 1'b0, 1'b0, 1'b0, 6'd0);

    // Unknown EX index ignored while no EX branch
    apply("x_idle",   1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 6'bxxxxxx);
    apply("x_chk",    1'b1, 32'hFFFF_FF40, 1'b0, 1'b0, 1'b0, 6'd0);

    // Mid-operation reset pulse between edges clears trained entries
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    model_reset();
    apply("mid_rst",  1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 6'd0);
    apply("mid_rst5", 1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
